// File: rtl/div_rr_sequencer_if.sv
// Request/response bundle for div_rr_sequencer.
// master: requesters + result consumer. slave: the sequencer.
interface div_rr_sequencer_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4,
    parameter int IDW   = 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quot;
    logic [WIDTH-1:0]      rsp_rem;
    logic                  rsp_dbz;

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );
endinterface

// File: rtl/div_rr_sequencer.sv
// Round-robin front-end sharing one restoring divider (one quotient bit
// per cycle, MSB first) between NREQ requesters. Results are returned
// tagged with the owner's ID on a valid/ready channel.
// Divide-by-zero: quot = all ones, rem = dividend, dbz = 1.
// Optional macro DIV_RR_SEQUENCER_PERF_EN adds saturating 16-bit
// perf_ops / perf_dbz completion counters.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrating; req_ready one-hot on the round-robin winner
// ITER  | restoring divide, bit counter counts down to 0
// DONE  | result held on rsp_*, waiting for rsp_ready
module div_rr_sequencer #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4,
    parameter int IDW   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   busy,
`ifdef DIV_RR_SEQUENCER_PERF_EN
    output logic [15:0]            perf_ops,
    output logic [15:0]            perf_dbz,
`endif
    div_rr_sequencer_if.slave      bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_quot_q, rsp_quot_d;
    logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic             rsp_dbz_q, rsp_dbz_d;

    logic [NREQ-1:0]  gnt_oh;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;
    logic [WIDTH-1:0] sel_dvd;
    logic [WIDTH-1:0] sel_dvs;
    logic             accept;
    logic             fire;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] pr_step;
    logic [WIDTH-1:0] quot_step;

    // Round-robin pick: first valid requester scanning up from ptr_q, wrapping.
    always_comb begin
        gnt_oh  = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_any && bus.req_valid[i] &&
                    (((int'(ptr_q) + k) % NREQ) == i)) begin
                    gnt_any   = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_id    = IDW'(i);
                end
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_dvd = bus.req_dividend[i*WIDTH +: WIDTH];
                sel_dvs = bus.req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && gnt_any;
    assign fire   = (state_q == S_DONE) && bus.rsp_ready;

    // One restoring step: bring down the next dividend bit, trial-subtract.
    always_comb begin
        trial     = {pr_q, dvd_q[cnt_q]};
        diff      = trial - {1'b0, dvs_q};
        qbit      = (trial >= {1'b0, dvs_q});
        pr_step   = qbit ? WIDTH'(diff) : WIDTH'(trial);
        quot_step = (quot_q << 1) | WIDTH'(qbit);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (sel_dvs == '0) ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.req_ready = (state_q == S_IDLE) ? gnt_oh : '0;
        bus.rsp_valid = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
    end

    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_quot = rsp_quot_q;
    assign bus.rsp_rem  = rsp_rem_q;
    assign bus.rsp_dbz  = rsp_dbz_q;

    // Datapath next values: capture on accept, iterate, load result registers.
    always_comb begin
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        pr_d       = pr_q;
        quot_d     = quot_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_quot_d = rsp_quot_q;
        rsp_rem_d  = rsp_rem_q;
        rsp_dbz_d  = rsp_dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d  = gnt_id;
                    dvd_d = sel_dvd;
                    dvs_d = sel_dvs;
                    ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
                    if (sel_dvs == '0) begin
                        rsp_id_d   = gnt_id;
                        rsp_quot_d = '1;
                        rsp_rem_d  = sel_dvd;
                        rsp_dbz_d  = 1'b1;
                    end else begin
                        cnt_d  = CW'(WIDTH - 1);
                        pr_d   = '0;
                        quot_d = '0;
                    end
                end
            end
            S_ITER: begin
                pr_d   = pr_step;
                quot_d = quot_step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    rsp_id_d   = id_q;
                    rsp_quot_d = quot_step;
                    rsp_rem_d  = pr_step;
                    rsp_dbz_d  = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            pr_q       <= '0;
            quot_q     <= '0;
            id_q       <= '0;
            rsp_id_q   <= '0;
            rsp_quot_q <= '0;
            rsp_rem_q  <= '0;
            rsp_dbz_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            pr_q       <= pr_d;
            quot_q     <= quot_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_quot_q <= rsp_quot_d;
            rsp_rem_q  <= rsp_rem_d;
            rsp_dbz_q  <= rsp_dbz_d;
        end
    end

`ifdef DIV_RR_SEQUENCER_PERF_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_dbz_q, perf_dbz_d;

    // Saturating completion counters.
    always_comb begin
        perf_ops_d = perf_ops_q;
        perf_dbz_d = perf_dbz_q;
        if (fire && (perf_ops_q != 16'hFFFF)) begin
            perf_ops_d = perf_ops_q + 16'd1;
        end
        if (fire && rsp_dbz_q && (perf_dbz_q != 16'hFFFF)) begin
            perf_dbz_d = perf_dbz_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q <= '0;
            perf_dbz_q <= '0;
        end else begin
            perf_ops_q <= perf_ops_d;
            perf_dbz_q <= perf_dbz_d;
        end
    end

    assign perf_ops = perf_ops_q;
    assign perf_dbz = perf_dbz_q;
`else
    logic unused_fire;
    assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_div_rr_sequencer.sv
// Bench for div_rr_sequencer: directed test-plan cases followed by random
// traffic, checked against a transaction-level model (integer / and %,
// a round-robin pointer, fixed latencies).
module tb_div_rr_sequencer;
    localparam int NREQ  = 3;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
    localparam int VW    = NREQ * WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef DIV_RR_SEQUENCER_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_dbz;
`endif

    int vectors = 0;
    int miscompares = 0;
    int m_ptr = 0;
    int m_ops = 0;
    int m_dbz = 0;

    div_rr_sequencer_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    div_rr_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
`ifdef DIV_RR_SEQUENCER_PERF_EN
        .perf_ops (perf_ops),
        .perf_dbz (perf_dbz),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == (ptr + k) % NREQ && v[i]) return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] pack3(input int x0, input int x1, input int x2);
        return {WIDTH'(x2), WIDTH'(x1), WIDTH'(x0)};
    endfunction

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [NREQ-1:0] v, input logic [VW-1:0] dvd,
                          input logic [VW-1:0] dvs, input int hold);
        int g;
        int lat;
        int a;
        int b;
        int eq;
        int er;
        int ed;
        bus.req_valid    = v;
        bus.req_dividend = dvd;
        bus.req_divisor  = dvs;
        bus.rsp_ready    = 1'b0;
        #1;
        g = model_grant(v, m_ptr);
        check("req_ready_idle", bus.req_ready, (g < 0) ? 0 : (1 << g));
        check("busy_idle", busy, 0);
        if (g < 0) begin
            @(negedge clk);
            check("busy_no_grant", busy, 0);
            return;
        end
        a = int'(WIDTH'(dvd >> (g * WIDTH)));
        b = int'(WIDTH'(dvs >> (g * WIDTH)));
        if (b == 0) begin
            eq = (1 << WIDTH) - 1; er = a; ed = 1; lat = 1;
        end else begin
            eq = a / b; er = a % b; ed = 0; lat = WIDTH + 1;
        end
        m_ptr = (g + 1) % NREQ;
        @(posedge clk);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            check("rsp_valid_latency", bus.rsp_valid, (n == lat) ? 1 : 0);
            check("busy_active", busy, 1);
            if (n == 1) begin
                check("req_ready_active", bus.req_ready, 0);
                bus.req_valid    = NREQ'($urandom);
                bus.req_dividend = VW'($urandom);
                bus.req_divisor  = VW'($urandom);
            end
        end
        check("rsp_id", bus.rsp_id, g);
        check("rsp_quot", bus.rsp_quot, eq);
        check("rsp_rem", bus.rsp_rem, er);
        check("rsp_dbz", bus.rsp_dbz, ed);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_id", bus.rsp_id, g);
            check("hold_quot", bus.rsp_quot, eq);
            check("hold_rem", bus.rsp_rem, er);
            check("hold_dbz", bus.rsp_dbz, ed);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        check("rsp_valid_cleared", bus.rsp_valid, 0);
        check("busy_cleared", busy, 0);
        if (m_ops < 65535) m_ops++;
        if (ed == 1 && m_dbz < 65535) m_dbz++;
    endtask

    initial begin
        logic [VW-1:0] rdvd;
        logic [VW-1:0] rdvs;
        int b;

        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b0;
        rst_n            = 1'b0;
        #1;
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_quot", bus.rsp_quot, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 13/3 from requester 0, divide-by-zero from requester 1.
        run_op(3'b001, pack3(13, 0, 0), pack3(3, 1, 1), 0);
        run_op(3'b010, pack3(0, 9, 0), pack3(1, 0, 1), 0);
        // Both 0 and 1 valid continuously: 0,1,0,1.
        for (int r = 0; r < 4; r++) begin
            run_op(3'b011, pack3(15, 2, 0), pack3(1, 7, 1), 0);
        end
        // Back-pressure for 6 cycles, then an accept on the very next cycle.
        run_op(3'b001, pack3(13, 0, 0), pack3(3, 1, 1), 6);
        run_op(3'b100, pack3(0, 0, 11), pack3(1, 1, 4), 0);

        // Reset mid-operation; pointer is 1 after this accept, reset brings it to 0.
        bus.req_valid    = 3'b001;
        bus.req_dividend = pack3(13, 0, 0);
        bus.req_divisor  = pack3(3, 1, 1);
        #1;
        check("rst_op_grant", bus.req_ready, 3'b001);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_req_ready", bus.req_ready, 0);
        check("abort_id", bus.rsp_id, 0);
        check("abort_quot", bus.rsp_quot, 0);
        check("abort_rem", bus.rsp_rem, 0);
        check("abort_dbz", bus.rsp_dbz, 0);
        m_ptr = 0;
        m_ops = 0;
        m_dbz = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < WIDTH + 3; c++) begin
            @(negedge clk);
            check("post_abort_no_rsp", bus.rsp_valid, 0);
        end
        run_op(3'b011, pack3(5, 6, 0), pack3(2, 3, 1), 0);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            rdvd = '0;
            rdvs = '0;
            for (int i = 0; i < NREQ; i++) begin
                b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
                rdvd = rdvd | (VW'($urandom_range(0, 15)) << (i * WIDTH));
                rdvs = rdvs | (VW'(b) << (i * WIDTH));
            end
            run_op(NREQ'($urandom_range(0, 7)), rdvd, rdvs, int'($urandom_range(0, 3)));
        end

`ifdef DIV_RR_SEQUENCER_PERF_EN
        check("perf_ops", perf_ops, m_ops);
        check("perf_dbz", perf_dbz, m_dbz);
        force dut.perf_ops_q = 16'hFFFF;
        #1;
        release dut.perf_ops_q;
        m_ops = 65535;
        run_op(3'b001, pack3(7, 0, 0), pack3(2, 1, 1), 0);
        check("perf_ops_saturate", perf_ops, m_ops);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
